// File: rtl/logic_unit_pkg.sv
// Shared encodings for the logic unit: operation codes and FSM states.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op.sv
// Combinational bitwise operator shared by first and accumulating beats.
import logic_unit_pkg::*;

module logic_op #(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic unit with optional multi-beat accumulation and a one-entry result hold.
// Handshake: a beat moves when in_valid && in_ready; a result moves when out_valid && out_ready.
import logic_unit_pkg::*;

module logic_unit #(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       op,
  input  logic             select,
  input  logic             accumulate,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [1:0]       dbg_state
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             parity_q;

  logic             beat;
  logic             first_beat;
  logic             acc_mode;
  logic             completes;
  op_e              op_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result_d;

  // A HOLD slot frees up in the same cycle it drains, giving one op per cycle.
  assign in_ready   = (state_q != ST_HOLD) || out_ready;
  assign beat       = in_valid && in_ready;
  assign first_beat = (state_q != ST_ACCUM);
  assign acc_mode   = (ACC_EN != 0) && accumulate;
  assign completes  = first_beat ? (!acc_mode || last) : last;

  assign op_d = first_beat ? op_e'(op) : op_q;
  assign a_d  = first_beat ? operand1 : acc_q;

  logic_op #(.WIDTH(WIDTH)) u_logic_op (
    .op (op_d),
    .a  (a_d),
    .b  (operand2),
    .y  (acc_d)
  );

  assign result_d = select ? acc_d : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_OR;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_d;
      if (first_beat) op_q <= op_e'(op);
      if (completes) begin
        state_q  <= ST_HOLD;
        result_q <= result_d;
        zero_q   <= ~|result_d;
        parity_q <= ^result_d;
      end else begin
        state_q <= ST_ACCUM;
      end
    end else if (state_q == ST_HOLD && out_ready) begin
      state_q <= ST_IDLE;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_unit.sv
// Bench for logic_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_logic_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] op;
  logic       select;
  logic       accumulate;
  logic       last;
  logic       out_ready;

  logic       in_ready,  out_valid,  zero,  parity;
  logic [7:0] result;
  logic [1:0] dbg_state;
  logic       in_ready0, out_valid0, zero0, parity0;
  logic [7:0] result0;
  logic [1:0] dbg_state0;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  always #5 clk = ~clk;

  logic_unit #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .op(op), .select(select),
    .accumulate(accumulate), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .parity(parity),
    .dbg_state(dbg_state)
  );

  logic_unit #(.WIDTH(8), .ACC_EN(0)) dut_noacc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .operand1(operand1), .operand2(operand2), .op(op), .select(select),
    .accumulate(accumulate), .last(last), .out_valid(out_valid0),
    .out_ready(out_ready), .result(result0), .zero(zero0), .parity(parity0),
    .dbg_state(dbg_state0)
  );

  // Reference model: an operation is operand1, its op, and the list of operand2 beats.
  bit         m_hold;
  bit         m_busy;
  logic [1:0] m_op;
  logic [7:0] m_op1;
  logic [7:0] op2_q[$];
  logic [7:0] m_result;
  bit         m_zero;
  bit         m_parity;

  function automatic logic [7:0] f(logic [1:0] o, logic [7:0] a, logic [7:0] b);
    case (o)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic bit m_ready();
    return m_hold ? out_ready : 1'b1;
  endfunction

  task automatic model_edge();
    logic [7:0] v;
    bit done;
    if (reset) begin
      m_hold = 0; m_busy = 0; m_op = 0; op2_q.delete();
      m_result = 0; m_zero = 1; m_parity = 0;
    end else if (in_valid && m_ready()) begin
      if (!m_busy) begin
        m_op = op; m_op1 = operand1; op2_q.delete(); op2_q.push_back(operand2);
        done = !accumulate || last;
      end else begin
        op2_q.push_back(operand2);
        done = last;
      end
      if (done) begin
        v = m_op1;
        foreach (op2_q[i]) v = f(m_op, v, op2_q[i]);
        m_result = select ? v : 8'h00;
        m_zero   = (m_result == 8'h00);
        m_parity = ^m_result;
        m_hold = 1; m_busy = 0;
      end else begin
        m_hold = 0; m_busy = 1;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0;
    end
  endtask

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver: one cycle of inputs, checked before and after the edge.
  task automatic step(input bit iv, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] o, input bit s, input bit ac, input bit la,
                      input bit ordy, input bit rst);
    in_valid = iv; operand1 = a; operand2 = b; op = o; select = s;
    accumulate = ac; last = la; out_ready = ordy; reset = rst;
    @(negedge clk);
    check_eq("in_ready", in_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out_valid", out_valid, m_hold);
    check_eq("result", result, m_result);
    check_eq("zero", zero, m_zero);
    check_eq("parity", parity, m_parity);
  endtask

  task automatic idle(input bit ordy);
    step(0, 8'h00, 8'h00, 2'd0, 1, 0, 0, ordy, 0);
  endtask

  initial begin
    reset = 1; in_valid = 0; operand1 = 0; operand2 = 0; op = 0;
    select = 0; accumulate = 0; last = 0; out_ready = 1;
    m_hold = 0; m_busy = 0; m_op = 0; m_op1 = 0;
    m_result = 0; m_zero = 1; m_parity = 0;
    @(posedge clk); #1;

    step(0, 8'h00, 8'h00, 2'd0, 0, 0, 0, 1, 1);
    check_eq("rst_result", result, 8'h00);
    check_eq("rst_zero", zero, 1'b1);
    check_eq("rst_valid", out_valid, 1'b0);

    // Single OR
    step(1, 8'hA5, 8'h0F, 2'd0, 1, 0, 0, 1, 0);
    check_eq("or_valid", out_valid, 1'b1);
    check_eq("or_result", result, 8'hAF);
    check_eq("or_zero", zero, 1'b0);
    check_eq("or_parity", parity, 1'b0);
    idle(1);
    check_eq("drain_valid", out_valid, 1'b0);
    check_eq("drain_result", result, 8'hAF);

    // Single AND with select low
    step(1, 8'hFF, 8'hFF, 2'd1, 0, 0, 0, 1, 0);
    check_eq("and_sel0_result", result, 8'h00);
    check_eq("and_sel0_zero", zero, 1'b1);
    check_eq("and_sel0_parity", parity, 1'b0);

    // Three-beat XOR accumulate
    step(1, 8'h01, 8'h02, 2'd2, 1, 1, 0, 1, 0);
    check_eq("acc_b1_valid", out_valid, 1'b0);
    step(1, 8'hEE, 8'h04, 2'd0, 1, 0, 0, 1, 0);
    check_eq("acc_b2_valid", out_valid, 1'b0);
    step(1, 8'hEE, 8'h80, 2'd1, 1, 0, 1, 1, 0);
    check_eq("acc_valid", out_valid, 1'b1);
    check_eq("acc_result", result, 8'h87);
    check_eq("acc_parity", parity, 1'b0);

    // Back-pressure then drain with a same-cycle OR beat
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h30, 8'h03, 2'd0, 1, 0, 0, 0, 0);
      check_eq("hold_result", result, 8'h87);
      check_eq("hold_ready", in_ready, 1'b0);
    end
    step(1, 8'h30, 8'h03, 2'd0, 1, 0, 0, 1, 0);
    check_eq("bp_new_result", result, 8'h33);
    check_eq("bp_new_valid", out_valid, 1'b1);

    // Reset in the middle of an accumulation
    step(1, 8'h11, 8'h22, 2'd0, 1, 1, 0, 1, 0);
    step(1, 8'h00, 8'h44, 2'd0, 1, 0, 0, 1, 0);
    check_eq("pre_rst_valid", out_valid, 1'b0);
    step(1, 8'h00, 8'h88, 2'd0, 1, 0, 1, 1, 1);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_result", result, 8'h00);
    step(1, 8'h00, 8'h0F, 2'd3, 1, 0, 0, 1, 0);
    check_eq("nor_result", result, 8'hF0);

    // Accumulate request on the ACC_EN=0 build completes in one beat
    step(1, 8'h0F, 8'hF0, 2'd2, 1, 1, 0, 1, 0);
    check_eq("noacc_valid", out_valid0, 1'b1);
    check_eq("noacc_result", result0, 8'hFF);
    check_eq("noacc_parity", parity0, 1'b0);
    step(1, 8'h00, 8'h00, 2'd0, 1, 0, 1, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>=1).
REQ-002 Parameter ACC_EN, default 1, enables multi-beat accumulate mode (0 = mode disabled).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 operand1  input  WIDTH  first operand (used on the first beat of an operation only).
REQ-008 operand2  input  WIDTH  second operand (used on every beat).
REQ-009 op  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-010 select  input  1  enable; 0 on the completing beat forces the result to zero.
REQ-011 accumulate  input  1  first beat starts a multi-beat operation.
REQ-012 last  input  1  marks the final beat of a multi-beat operation.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  WIDTH  registered result.
REQ-016 zero  output  1  registered flag, result == 0.
REQ-017 parity  output  1  registered flag, XOR-reduction of result.

Function
REQ-018 Beat accepted iff in_valid && in_ready; result accepted iff out_valid && out_ready.
REQ-019 States IDLE, ACCUM, HOLD; out_valid = (state == HOLD).
REQ-020 in_ready = 1 in IDLE and ACCUM; in HOLD in_ready = out_ready (throughput one op per cycle).
REQ-021 Beat accepted in IDLE, or in HOLD with out_ready, is a first beat: acc <= f(op, operand1, operand2); op latched for the whole operation.
REQ-022 First beat with accumulate=0, or accumulate=1 with last=1: next state HOLD, latency one cycle to out_valid.
REQ-023 First beat with accumulate=1 and last=0: next state ACCUM, out_valid stays/goes 0.
REQ-024 Beat accepted in ACCUM: acc <= f(latched op, acc, operand2); operand1, op and accumulate ignored; last=1 -> HOLD, else stay ACCUM.
REQ-025 On the completing beat, result <= select ? new acc : 0; zero and parity computed from that gated value, registered with result.
REQ-026 HOLD with out_ready=0: result, zero, parity, out_valid held stable; no beat accepted.
REQ-027 HOLD with out_ready=1 and no beat accepted: next state IDLE, out_valid 0; result retains last value.
REQ-028 ACC_EN=0: accumulate treated as 0, ACCUM unreachable.
REQ-029 Accumulator wraps nothing: all operations bitwise, width WIDTH, no carry.

Reset
REQ-030 reset=1 at a clock edge: state IDLE, out_valid 0, result 0, zero 1, parity 0, acc 0, latched op 00.
REQ-031 Reset overrides any concurrent beat or result handshake; a partial ACCUM operation is discarded without output.
REQ-032 First beat may be accepted on the cycle after reset deasserts.

Structure
REQ-033 Shared package logic_unit_pkg holds op encodings (OP_OR, OP_AND, OP_XOR, OP_NOR) and the state encoding.
REQ-034 One combinational sub-module logic_op (WIDTH-parametrised, inputs op, a, b; output y) implements f; instantiated once, operand a muxed between operand1 and acc.

Verification (WIDTH=8)
REQ-035 Reset, single OR 8'hA5,8'h0F, select=1 -> next cycle out_valid=1, result 8'hAF, zero 0, parity 0.
REQ-036 Single AND 8'hFF,8'hFF, select=0 -> result 8'h00, zero 1, parity 0.
REQ-037 Accumulate XOR: beat1 8'h01,8'h02 (accumulate=1); beat2 op2 8'h04; beat3 op2 8'h80, last=1 -> one cycle after beat3 result 8'h87, parity 0; no out_valid earlier.
REQ-038 Result held with out_ready=0 for 3 cycles -> result stable, in_ready 0; then out_ready=1 plus new OR beat same cycle -> beat accepted, new result next cycle.
REQ-039 Reset asserted in ACCUM after 2 beats -> out_valid 0 throughout; then single NOR 8'h00,8'h0F -> result 8'hF0.
REQ-040 ACC_EN=0 build: accumulate=1, last=0 XOR beat 8'h0F,8'hF0 -> completes as single beat, result 8'hFF, parity 0.
